// File: rtl/branch_ctrl.sv
// Multi-cycle branch/jump resolution controller: drives an external comparator,
// issues the redirect through a valid/ready handshake, then holds a fixed flush.
module branch_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [XLEN-1:0]  req_imm,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  output logic [XLEN-1:0]  cmp_a,
  output logic [XLEN-1:0]  cmp_b,
  output logic             cmp_branch,
  output logic [2:0]       cmp_funct3,
  input  logic             cmp_taken,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic [XLEN-1:0]  link_pc,
  output logic             misalign,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_REDIR, ST_FLUSH} state_t;

  state_t            state;
  logic [1:0]        kind_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   imm_q;
  logic [FW-1:0]     fcnt;
  logic              taken;
  logic [XLEN-1:0]   jalr_sum;
  logic [XLEN-1:0]   target;

  // cmp_a doubles as the captured rs1 while in EVAL, so JALR reads it here.
  always_comb begin
    taken    = 1'b0;
    jalr_sum = cmp_a + imm_q;
    target   = pc_q + imm_q;
    case (kind_q)
      2'b00:   taken = cmp_taken;
      2'b01:   taken = 1'b1;
      2'b10: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  assign req_ready = rst_n && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      kind_q       <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      fcnt         <= '0;
      cmp_a        <= '0;
      cmp_b        <= '0;
      cmp_branch   <= 1'b0;
      cmp_funct3   <= '0;
      redir_valid  <= 1'b0;
      redir_pc     <= '0;
      link_pc      <= '0;
      misalign     <= 1'b0;
      flush        <= 1'b0;
      busy         <= 1'b0;
      resolved_cnt <= '0;
      taken_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            kind_q     <= req_kind;
            pc_q       <= req_pc;
            imm_q      <= req_imm;
            cmp_a      <= req_rs1;
            cmp_b      <= req_rs2;
            cmp_funct3 <= req_funct3;
            cmp_branch <= (req_kind == 2'b00);
            link_pc    <= req_pc + XLEN'(4);
            busy       <= 1'b1;
            state      <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          cmp_a      <= '0;
          cmp_b      <= '0;
          cmp_funct3 <= '0;
          cmp_branch <= 1'b0;
          redir_pc   <= target;
          if (resolved_cnt != '1)
            resolved_cnt <= resolved_cnt + CNT_W'(1);
          if (taken) begin
            if (taken_cnt != '1)
              taken_cnt <= taken_cnt + CNT_W'(1);
            misalign    <= target[1];
            redir_valid <= 1'b1;
            state       <= ST_REDIR;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_REDIR: begin
          if (redir_ready) begin
            redir_valid <= 1'b0;
            misalign    <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              flush <= 1'b1;
              fcnt  <= FW'(FLUSH_CYCLES - 1);
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (fcnt == '0) begin
            flush <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            fcnt <= fcnt - FW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl with a behavioural branchComp stand-in.
module tb_branch_ctrl;

  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      req_kind = '0;
  logic [2:0]      req_funct3 = '0;
  logic [XLEN-1:0] req_pc = '0, req_imm = '0, req_rs1 = '0, req_rs2 = '0;
  logic [XLEN-1:0] cmp_a, cmp_b;
  logic            cmp_branch;
  logic [2:0]      cmp_funct3;
  logic            cmp_taken;
  logic            redir_valid;
  logic            redir_ready = 1'b1;
  logic [XLEN-1:0] redir_pc, link_pc;
  logic            misalign, flush, busy;
  logic [CW-1:0]   resolved_cnt, taken_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_funct3(req_funct3), .req_pc(req_pc), .req_imm(req_imm),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_branch(cmp_branch),
    .cmp_funct3(cmp_funct3), .cmp_taken(cmp_taken),
    .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_pc(redir_pc), .link_pc(link_pc), .misalign(misalign),
    .flush(flush), .busy(busy),
    .resolved_cnt(resolved_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the external branchComp.
  always_comb begin
    cmp_taken = 1'b0;
    if (cmp_branch) begin
      case (cmp_funct3)
        3'b000:  cmp_taken = (cmp_a == cmp_b);
        3'b001:  cmp_taken = (cmp_a != cmp_b);
        3'b100:  cmp_taken = ($signed(cmp_a) <  $signed(cmp_b));
        3'b101:  cmp_taken = ($signed(cmp_a) >= $signed(cmp_b));
        3'b110:  cmp_taken = (cmp_a <  cmp_b);
        3'b111:  cmp_taken = (cmp_a >= cmp_b);
        default: cmp_taken = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present a request for one edge; caller guarantees req_ready is high.
  task automatic issue(input logic [1:0] k, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    req_kind = k; req_funct3 = f3; req_pc = pc; req_imm = imm;
    req_rs1 = rs1; req_rs2 = rs2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_req_ready_low", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_redir_valid", 64'(redir_valid), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_cmp_branch", 64'(cmp_branch), 64'd0);
    check("rst_redir_pc", 64'(redir_pc), 64'd0);
    check("rst_link_pc", 64'(link_pc), 64'd0);
    check("rst_resolved", 64'(resolved_cnt), 64'd0);
    check("rst_taken", 64'(taken_cnt), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 64'(req_ready), 64'd1);

    // BEQ taken
    redir_ready = 1'b1;
    issue(2'b00, 3'b000, 32'h100, 32'h20, 32'd10, 32'd10);
    check("beq_cmp_branch", 64'(cmp_branch), 64'd1);
    check("beq_cmp_a", 64'(cmp_a), 64'd10);
    check("beq_cmp_b", 64'(cmp_b), 64'd10);
    check("beq_busy", 64'(busy), 64'd1);
    check("beq_ready_low", 64'(req_ready), 64'd0);
    tick();
    check("beq_redir_valid", 64'(redir_valid), 64'd1);
    check("beq_redir_pc", 64'(redir_pc), 64'h120);
    check("beq_link_pc", 64'(link_pc), 64'h104);
    check("beq_cmp_branch_off", 64'(cmp_branch), 64'd0);
    check("beq_cmp_a_off", 64'(cmp_a), 64'd0);
    check("beq_resolved", 64'(resolved_cnt), 64'd1);
    check("beq_taken", 64'(taken_cnt), 64'd1);
    tick();
    check("beq_flush1", 64'(flush), 64'd1);
    check("beq_redir_drop", 64'(redir_valid), 64'd0);
    tick();
    check("beq_flush2", 64'(flush), 64'd1);
    tick();
    check("beq_flush_end", 64'(flush), 64'd0);
    check("beq_idle_ready", 64'(req_ready), 64'd1);
    check("beq_idle_busy", 64'(busy), 64'd0);

    // BLTU not taken, fresh counters
    do_reset();
    issue(2'b00, 3'b110, 32'h180, 32'h40, 32'hFFFF_FFFE, 32'd1);
    check("bltu_cmp_branch", 64'(cmp_branch), 64'd1);
    check("bltu_ready_low", 64'(req_ready), 64'd0);
    tick();
    check("bltu_no_redir", 64'(redir_valid), 64'd0);
    check("bltu_ready_back", 64'(req_ready), 64'd1);
    check("bltu_resolved", 64'(resolved_cnt), 64'd1);
    check("bltu_taken", 64'(taken_cnt), 64'd0);

    // JALR with misaligned target
    issue(2'b10, 3'b000, 32'h200, 32'h0, 32'h1003, 32'h0);
    check("jalr_cmp_branch", 64'(cmp_branch), 64'd0);
    tick();
    check("jalr_redir_valid", 64'(redir_valid), 64'd1);
    check("jalr_redir_pc", 64'(redir_pc), 64'h1002);
    check("jalr_misalign", 64'(misalign), 64'd1);
    check("jalr_link_pc", 64'(link_pc), 64'h204);
    tick();
    check("jalr_flush", 64'(flush), 64'd1);
    check("jalr_misalign_off", 64'(misalign), 64'd0);
    tick();
    tick();
    check("jalr_counts", 64'({resolved_cnt, taken_cnt}), 64'({4'd2, 4'd1}));

    // JAL with 3 cycles of backpressure and an ignored request pulse
    redir_ready = 1'b0;
    issue(2'b01, 3'b000, 32'h300, 32'h40, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_valid_held", 64'(redir_valid), 64'd1);
      check("bp_pc_held", 64'(redir_pc), 64'h340);
      check("bp_link_held", 64'(link_pc), 64'h304);
      check("bp_no_flush", 64'(flush), 64'd0);
      req_kind = 2'b01; req_pc = 32'h999; req_imm = 32'h4;
      req_valid = (i == 1);
      tick();
    end
    req_valid = 1'b0;
    check("bp_valid_4th", 64'(redir_valid), 64'd1);
    check("bp_pc_4th", 64'(redir_pc), 64'h340);
    check("bp_no_flush_4th", 64'(flush), 64'd0);
    redir_ready = 1'b1;
    tick();
    check("bp_flush_start", 64'(flush), 64'd1);
    check("bp_valid_drop", 64'(redir_valid), 64'd0);
    tick();
    tick();
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_counts", 64'({resolved_cnt, taken_cnt}), 64'({4'd3, 4'd2}));

    // Wrap-around target
    issue(2'b01, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0);
    tick();
    check("wrap_redir_pc", 64'(redir_pc), 64'h10);
    check("wrap_link_pc", 64'(link_pc), 64'hFFFF_FFF4);
    tick();
    tick();
    tick();

    // BLT signed taken, negative offset
    issue(2'b00, 3'b100, 32'h400, 32'hFFFF_FFF8, 32'hFFFF_FFFB, 32'd3);
    tick();
    check("blt_redir_valid", 64'(redir_valid), 64'd1);
    check("blt_redir_pc", 64'(redir_pc), 64'h3F8);
    check("blt_misalign", 64'(misalign), 64'd0);
    tick();
    tick();
    tick();

    // Reserved kind resolves not-taken but still counts
    issue(2'b11, 3'b000, 32'h500, 32'h4, 32'd7, 32'd7);
    check("rsv_cmp_branch", 64'(cmp_branch), 64'd0);
    tick();
    check("rsv_no_redir", 64'(redir_valid), 64'd0);
    check("rsv_ready", 64'(req_ready), 64'd1);
    check("rsv_counts", 64'({resolved_cnt, taken_cnt}), 64'({4'd6, 4'd4}));

    // Reset while a redirect is outstanding
    redir_ready = 1'b0;
    issue(2'b01, 3'b000, 32'h600, 32'h8, 32'h0, 32'h0);
    tick();
    check("rmr_valid_before", 64'(redir_valid), 64'd1);
    rst_n = 1'b0;
    req_valid = 1'b1;
    tick();
    check("rmr_valid_drop", 64'(redir_valid), 64'd0);
    check("rmr_resolved", 64'(resolved_cnt), 64'd0);
    check("rmr_taken", 64'(taken_cnt), 64'd0);
    check("rmr_redir_pc", 64'(redir_pc), 64'd0);
    check("rmr_ready_in_rst", 64'(req_ready), 64'd0);
    tick();
    check("rmr_no_accept", 64'(busy), 64'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rmr_ready_after", 64'(req_ready), 64'd1);
    redir_ready = 1'b1;

    // Counter saturation with not-taken BNE
    for (int i = 0; i < 17; i++) begin
      issue(2'b00, 3'b001, 32'h700, 32'h10, 32'd5, 32'd5);
      tick();
      if (i == 14) check("sat_reach", 64'(resolved_cnt), 64'd15);
    end
    check("sat_hold", 64'(resolved_cnt), 64'd15);
    check("sat_taken", 64'(taken_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
